// File: rtl/uart_frame_tx.sv
// Framed 8N1 serial transmitter: FIFO-buffered words go out as
// HEADER, data bytes MSB-first, then an optional modulo-256 checksum byte.
module uart_frame_tx #(
    parameter int          DATA_BYTES   = 2,
    parameter logic [7:0]  HEADER       = 8'd123,
    parameter int          CLKS_PER_BIT = 40,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          CHECKSUM_EN  = 1
) (
    input  logic                    clk_20m,
    input  logic                    rst,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic                    data_rdy,
    output logic                    full,
    output logic                    busy,
    output logic                    tx,
    output logic                    frame_done,
    output logic                    overflow
);

    localparam int W        = 8 * DATA_BYTES;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int CLK_W    = $clog2(CLKS_PER_BIT);
    localparam int LAST_IDX = DATA_BYTES + ((CHECKSUM_EN != 0) ? 1 : 0);
    localparam int BYTE_W   = $clog2(LAST_IDX + 1);

    localparam logic [CLK_W-1:0]  CLK_LAST  = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(LAST_IDX);
    localparam logic [BYTE_W-1:0] DATA_LAST = BYTE_W'(DATA_BYTES);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, BITS, STOP} state_t;

    state_t state, state_next;

    logic [W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_next;
    logic              push, pop, empty;

    logic [W-1:0]      word_q;
    logic [CLK_W-1:0]  clk_cnt;
    logic [2:0]        bit_idx;
    logic [BYTE_W-1:0] byte_idx;
    logic [7:0]        csum;
    logic [7:0]        cur_byte;
    logic              bit_end, frame_end, tx_next;

    assign empty   = (count == '0);
    // full is the registered flag, so a drop is decided before any same-edge pop
    assign push    = data_rdy && !full;
    assign bit_end = (clk_cnt == CLK_LAST);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // NOTE: the storage array has no reset; only pointers and count define validity.
    always_ff @(posedge clk_20m) begin
        if (push) mem[wr_ptr] <= data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_20m) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            full     <= (count_next == CNT_FULL);
            overflow <= data_rdy && full;
        end
    end

    always_ff @(posedge clk_20m) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        frame_end  = 1'b0;
        tx_next    = 1'b1;

        if (byte_idx == '0)             cur_byte = HEADER;
        else if (byte_idx <= DATA_LAST) cur_byte = word_q[W-1 -: 8];
        else                            cur_byte = csum;

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (bit_end) state_next = BITS;
            end
            BITS: begin
                tx_next = cur_byte[bit_idx];
                if (bit_end && bit_idx == 3'd7) state_next = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx != BYTE_LAST) begin
                        state_next = START;
                    end else begin
                        frame_end = 1'b1;
                        if (!empty) begin
                            pop        = 1'b1;
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // tx and frame_done are registered, trailing the state by one cycle
    always_ff @(posedge clk_20m) begin
        if (rst) begin
            tx         <= 1'b1;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            word_q     <= '0;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            csum       <= '0;
        end else begin
            tx         <= tx_next;
            frame_done <= frame_end;
            busy       <= (state != IDLE) || !empty;
            if (pop) begin
                word_q   <= mem[rd_ptr];
                clk_cnt  <= '0;
                bit_idx  <= '0;
                byte_idx <= '0;
                csum     <= '0;
            end else if (state != IDLE) begin
                clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
                if (bit_end && state == BITS) bit_idx <= bit_idx + 1'b1;
                if (bit_end && state == STOP) begin
                    byte_idx <= byte_idx + 1'b1;
                    csum     <= csum + cur_byte;
                    // data bytes leave from the top of the word
                    if (byte_idx != '0) word_q <= word_q << 8;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: three instances cover the default,
// 3-byte/no-checksum and fast-baud configurations.
module tb_uart_frame_tx;

    logic clk_20m = 1'b0;
    always #25 clk_20m = ~clk_20m;

    logic        rst = 1'b1;

    logic [15:0] data0 = '0;
    logic        rdy0 = 1'b0;
    logic        full0, busy0, tx0, fd0, ovf0;

    logic [23:0] data3 = '0;
    logic        rdy3 = 1'b0;
    logic        full3, busy3, tx3, fd3, ovf3;

    logic [15:0] data4 = '0;
    logic        rdy4 = 1'b0;
    logic        full4, busy4, tx4, fd4, ovf4;

    uart_frame_tx dut0 (
        .clk_20m(clk_20m), .rst(rst), .data(data0), .data_rdy(rdy0),
        .full(full0), .busy(busy0), .tx(tx0), .frame_done(fd0), .overflow(ovf0)
    );

    uart_frame_tx #(.DATA_BYTES(3), .CHECKSUM_EN(0)) dut3 (
        .clk_20m(clk_20m), .rst(rst), .data(data3), .data_rdy(rdy3),
        .full(full3), .busy(busy3), .tx(tx3), .frame_done(fd3), .overflow(ovf3)
    );

    uart_frame_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk_20m(clk_20m), .rst(rst), .data(data4), .data_rdy(rdy4),
        .full(full4), .busy(busy4), .tx(tx4), .frame_done(fd4), .overflow(ovf4)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] rx_bytes [64];
    logic [7:0] exp_b    [64];
    int rx_wait, rx_glitch, rx_framing, rx_fd_good, rx_fd_bad;
    bit rx_timeout;

    task automatic tick;
        @(posedge clk_20m);
        #1;
    endtask

    function automatic logic tx_of(input int sel);
        case (sel)
            3:       return tx3;
            4:       return tx4;
            default: return tx0;
        endcase
    endfunction

    function automatic logic fd_of(input int sel);
        case (sel)
            3:       return fd3;
            4:       return fd4;
            default: return fd0;
        endcase
    endfunction

    // Waits (bounded) for the first start bit, then samples every cycle of
    // nframes contiguous frames; a bit whose level changes inside its period is a glitch.
    task automatic rx_frames(input int sel, input int cpb, input int nbytes,
                             input int nframes, input int wait_limit);
        int flen;
        int s;
        logic v;
        logic [9:0] bits;
        rx_timeout = 1'b0;
        rx_wait    = 0;
        rx_glitch  = 0;
        rx_framing = 0;
        rx_fd_good = 0;
        rx_fd_bad  = 0;
        bits       = '0;
        while (tx_of(sel) !== 1'b0) begin
            if (rx_wait >= wait_limit) begin
                rx_timeout = 1'b1;
                return;
            end
            tick();
            rx_wait++;
        end
        flen = nbytes * 10 * cpb;
        for (int f = 0; f < nframes; f++) begin
            for (int b = 0; b < nbytes; b++) begin
                for (int p = 0; p < 10; p++) begin
                    for (int c = 0; c < cpb; c++) begin
                        if (!(f == 0 && b == 0 && p == 0 && c == 0)) tick();
                        v = tx_of(sel);
                        if (c == 0) bits[p] = v;
                        else if (v !== bits[p]) rx_glitch++;
                        s = (b * 10 + p) * cpb + c;
                        if (fd_of(sel) === 1'b1) begin
                            if (s == flen - 1) rx_fd_good++;
                            else               rx_fd_bad++;
                        end
                    end
                end
                if (bits[0] !== 1'b0 || bits[9] !== 1'b1) rx_framing++;
                rx_bytes[f * nbytes + b] = bits[8:1];
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (tx0 !== 1'b1)   begin failures++; $display("FAIL rst_tx got=%b exp=1", tx0); end
        checks++; if (full0 !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", full0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy0); end
        checks++; if (fd0 !== 1'b0)   begin failures++; $display("FAIL rst_frame_done got=%b exp=0", fd0); end
        checks++; if (ovf0 !== 1'b0)  begin failures++; $display("FAIL rst_overflow got=%b exp=0", ovf0); end
        checks++; if ({tx3, tx4} !== 2'b11) begin failures++; $display("FAIL rst_tx_other got=%b exp=11", {tx3, tx4}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_frame;
        exp_b[0] = 8'h7B; exp_b[1] = 8'hAB; exp_b[2] = 8'hCD; exp_b[3] = 8'hF3;
        fork
            begin
                data0 = 16'hABCD; rdy0 = 1'b1;
                tick();
                rdy0 = 1'b0;
                tick();
                checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL t1_busy_rise got=%b exp=1", busy0); end
            end
            rx_frames(0, 40, 4, 1, 20);
        join
        checks++; if (rx_timeout || rx_wait != 3) begin failures++; $display("FAIL t1_start_latency got=%0d timeout=%0d exp=3", rx_wait, rx_timeout); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rx_bytes[i] !== exp_b[i]) begin failures++; $display("FAIL t1_byte%0d got=%h exp=%h", i, rx_bytes[i], exp_b[i]); end
        end
        checks++; if (rx_glitch != 0 || rx_framing != 0) begin failures++; $display("FAIL t1_bit_timing glitch=%0d framing=%0d exp=0", rx_glitch, rx_framing); end
        checks++; if (rx_fd_good != 1 || rx_fd_bad != 0) begin failures++; $display("FAIL t1_frame_done good=%0d bad=%0d exp=1/0", rx_fd_good, rx_fd_bad); end
        tick();
        checks++; if (busy0 !== 1'b0 || tx0 !== 1'b1) begin failures++; $display("FAIL t1_idle_after busy=%b tx=%b exp=0/1", busy0, tx0); end
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 5; k++) begin
            exp_b[k*4]   = 8'h7B;
            exp_b[k*4+1] = 8'h00;
            exp_b[k*4+2] = 8'(k + 1);
            exp_b[k*4+3] = 8'(8'h7B + k + 1);
        end
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    data0 = 16'(i); rdy0 = 1'b1;
                    tick();
                    if (i == 4) begin
                        checks++; if (full0 !== 1'b0) begin failures++; $display("FAIL t2_full_after4 got=%b exp=0", full0); end
                    end
                    if (i == 5) begin
                        checks++; if (full0 !== 1'b1) begin failures++; $display("FAIL t2_full_after5 got=%b exp=1", full0); end
                    end
                    if (i == 6) begin
                        checks++; if (ovf0 !== 1'b1) begin failures++; $display("FAIL t2_overflow got=%b exp=1", ovf0); end
                    end
                end
                rdy0 = 1'b0;
                tick();
                checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL t2_overflow_pulse_len got=%b exp=0", ovf0); end
            end
            rx_frames(0, 40, 4, 5, 20);
        join
        checks++; if (rx_timeout) begin failures++; $display("FAIL t2_timeout got=1 exp=0"); end
        for (int i = 0; i < 20; i++) begin
            checks++; if (rx_bytes[i] !== exp_b[i]) begin failures++; $display("FAIL t2_byte%0d got=%h exp=%h", i, rx_bytes[i], exp_b[i]); end
        end
        checks++; if (rx_glitch != 0 || rx_framing != 0) begin failures++; $display("FAIL t2_gapless glitch=%0d framing=%0d exp=0", rx_glitch, rx_framing); end
        checks++; if (rx_fd_good != 5 || rx_fd_bad != 0) begin failures++; $display("FAIL t2_frame_done good=%0d bad=%0d exp=5/0", rx_fd_good, rx_fd_bad); end
        repeat (50) tick();
        checks++; if (busy0 !== 1'b0 || tx0 !== 1'b1) begin failures++; $display("FAIL t2_dropped_not_sent busy=%b tx=%b exp=0/1", busy0, tx0); end
    endtask

    task automatic test_three_bytes_no_checksum;
        exp_b[0] = 8'h7B; exp_b[1] = 8'h12; exp_b[2] = 8'h34; exp_b[3] = 8'h56;
        fork
            begin
                data3 = 24'h123456; rdy3 = 1'b1;
                tick();
                rdy3 = 1'b0;
            end
            rx_frames(3, 40, 4, 1, 20);
        join
        checks++; if (rx_timeout || rx_wait != 3) begin failures++; $display("FAIL t3_start_latency got=%0d timeout=%0d exp=3", rx_wait, rx_timeout); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rx_bytes[i] !== exp_b[i]) begin failures++; $display("FAIL t3_byte%0d got=%h exp=%h", i, rx_bytes[i], exp_b[i]); end
        end
        checks++; if (rx_fd_good != 1 || rx_fd_bad != 0) begin failures++; $display("FAIL t3_frame_len good=%0d bad=%0d exp=1/0", rx_fd_good, rx_fd_bad); end
        tick();
        checks++; if (busy3 !== 1'b0 || tx3 !== 1'b1) begin failures++; $display("FAIL t3_no_checksum_byte busy=%b tx=%b exp=0/1", busy3, tx3); end
    endtask

    task automatic test_fast_baud;
        exp_b[0] = 8'h7B; exp_b[1] = 8'h00; exp_b[2] = 8'hFF; exp_b[3] = 8'h7A;
        fork
            begin
                data4 = 16'h00FF; rdy4 = 1'b1;
                tick();
                rdy4 = 1'b0;
            end
            rx_frames(4, 4, 4, 1, 20);
        join
        checks++; if (rx_timeout) begin failures++; $display("FAIL t4_timeout got=1 exp=0"); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rx_bytes[i] !== exp_b[i]) begin failures++; $display("FAIL t4_byte%0d got=%h exp=%h", i, rx_bytes[i], exp_b[i]); end
        end
        checks++; if (rx_glitch != 0 || rx_framing != 0) begin failures++; $display("FAIL t4_bit_period glitch=%0d framing=%0d exp=0", rx_glitch, rx_framing); end
        checks++; if (rx_fd_good != 1 || rx_fd_bad != 0) begin failures++; $display("FAIL t4_frame_len good=%0d bad=%0d exp=1/0", rx_fd_good, rx_fd_bad); end
        tick();
        checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL t4_busy_after got=%b exp=0", busy4); end
    endtask

    task automatic test_reset_mid_frame;
        int bad_tx;
        int bad_fd;
        int bad_busy;
        for (int i = 0; i < 3; i++) begin
            data0 = 16'(16'h1111 * (i + 1)); rdy0 = 1'b1;
            tick();
        end
        rdy0 = 1'b0;
        // now just after the third push edge; 598 more edges lands inside the first data byte's bits
        repeat (598) tick();
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL t5_busy_before got=%b exp=1", busy0); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (tx0 !== 1'b1)   begin failures++; $display("FAIL t5_tx got=%b exp=1", tx0); end
        checks++; if (full0 !== 1'b0) begin failures++; $display("FAIL t5_full got=%b exp=0", full0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL t5_busy got=%b exp=0", busy0); end
        checks++; if (fd0 !== 1'b0 || ovf0 !== 1'b0) begin failures++; $display("FAIL t5_pulses fd=%b ovf=%b exp=0/0", fd0, ovf0); end
        bad_tx = 0; bad_fd = 0; bad_busy = 0;
        repeat (2000) begin
            tick();
            if (tx0 !== 1'b1)   bad_tx++;
            if (fd0 !== 1'b0)   bad_fd++;
            if (busy0 !== 1'b0) bad_busy++;
        end
        checks++; if (bad_tx != 0 || bad_fd != 0 || bad_busy != 0) begin failures++; $display("FAIL t5_queue_discarded tx=%0d fd=%0d busy=%0d exp=0", bad_tx, bad_fd, bad_busy); end
        exp_b[0] = 8'h7B; exp_b[1] = 8'h01; exp_b[2] = 8'h02; exp_b[3] = 8'h7E;
        fork
            begin
                data0 = 16'h0102; rdy0 = 1'b1;
                tick();
                rdy0 = 1'b0;
            end
            rx_frames(0, 40, 4, 1, 20);
        join
        checks++; if (rx_timeout || rx_wait != 3) begin failures++; $display("FAIL t5_restart_latency got=%0d timeout=%0d exp=3", rx_wait, rx_timeout); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rx_bytes[i] !== exp_b[i]) begin failures++; $display("FAIL t5_byte%0d got=%h exp=%h", i, rx_bytes[i], exp_b[i]); end
        end
        tick();
    endtask

    task automatic test_push_pop_full;
        // pushes on edges E0..E4; the first frame's final stop cycle pops at E1601
        for (int i = 0; i < 5; i++) begin
            data0 = 16'(16'h00A0 + i); rdy0 = 1'b1;
            tick();
        end
        rdy0 = 1'b0;
        repeat (1596) tick();
        checks++; if (full0 !== 1'b1) begin failures++; $display("FAIL t6_full_before got=%b exp=1", full0); end
        data0 = 16'h00AA; rdy0 = 1'b1;
        tick();
        rdy0 = 1'b0;
        checks++; if (fd0 !== 1'b1)   begin failures++; $display("FAIL t6_pop_edge_frame_done got=%b exp=1", fd0); end
        checks++; if (ovf0 !== 1'b1)  begin failures++; $display("FAIL t6_overflow got=%b exp=1", ovf0); end
        checks++; if (full0 !== 1'b0) begin failures++; $display("FAIL t6_full_after_pop got=%b exp=0", full0); end
        tick();
        checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL t6_overflow_pulse_len got=%b exp=0", ovf0); end
        data0 = 16'h00BB; rdy0 = 1'b1;
        tick();
        rdy0 = 1'b0;
        checks++; if (full0 !== 1'b1 || ovf0 !== 1'b0) begin failures++; $display("FAIL t6_count_dropped_by_one full=%b ovf=%b exp=1/0", full0, ovf0); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #(50 * 60000);
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_three_bytes_no_checksum();
        test_fast_baud();
        test_reset_mid_frame();
        test_push_pop_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
Parametrised framed serial transmitter; successor to the fixed 16-bit header+word UART sender.
- Each sample word is buffered in an internal FIFO, so producer strobes arriving during an active frame are queued rather than lost.
- Each word is sent as one frame: header byte, then data bytes MSB-first, then an optional 8-bit checksum.
- Includes its own 8N1 bit serialiser. Sits between the TDC/measurement datapath and the board UART pin.

Parameters:
DATA_BYTES, 2, bytes per data word (1..8); data width = 8*DATA_BYTES
HEADER, 8'd123, frame sync byte sent first
CLKS_PER_BIT, 40, clk_20m cycles per serial bit (20 MHz / 500 kbaud); min 2
FIFO_DEPTH, 4, word FIFO entries; power of two, >= 2
CHECKSUM_EN, 1, 1 = append checksum byte, 0 = omit

Ports:
clk_20m  in  1  system clock, 20 MHz
rst  in  1  synchronous reset, active-high
data  in  8*DATA_BYTES  word to transmit, sampled on the push edge
data_rdy  in  1  push strobe; each high cycle is one push request
full  out  1  FIFO full, registered
busy  out  1  high while a frame is in progress or the FIFO is non-empty
tx  out  1  serial line, idle high
frame_done  out  1  one-cycle pulse at the end of each frame's last stop bit
overflow  out  1  one-cycle pulse when a push is dropped

Behaviour:
Reset:
- On rst: tx=1, full=0, busy=0, frame_done=0, overflow=0.
- FIFO is emptied, FSM goes to IDLE, bit and byte counters clear.
- Reset mid-frame aborts the frame immediately: tx is 1 from the next edge, no frame_done.

FIFO:
- Push when data_rdy=1 and full=0.
- If data_rdy=1 and full=1: word dropped, overflow pulses for 1 cycle. This holds even if a pop occurs on the same edge, because full is evaluated before the pop.
- A simultaneous push and pop leaves the count unchanged.

Frame FSM states: IDLE, START, BITS, STOP.
- IDLE: if the FIFO is non-empty, pop the head word into the shift register, select byte 0 (HEADER), clear the checksum accumulator, and go to START. The pop occurs the cycle after the word becomes visible, so the first start bit begins on the 2nd edge after the push edge.
- START: tx=0 for CLKS_PER_BIT cycles, then BITS.
- BITS: 8 data bits, LSB first, each held CLKS_PER_BIT cycles, then STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then:
  - more bytes in the frame: START for the next byte, with no extra gap;
  - last byte, FIFO non-empty: pop and START directly, no idle gap;
  - last byte, FIFO empty: IDLE.
  - In both last-byte cases frame_done pulses on the final stop-bit cycle.

Byte sequence:
- HEADER, then data[8*DATA_BYTES-1 -: 8] down to data[7:0].
- If CHECKSUM_EN=1, the checksum byte follows: sum mod 256 of HEADER and all data bytes.

Timing:
- Frame length = (1 + DATA_BYTES + CHECKSUM_EN) * 10 * CLKS_PER_BIT cycles.
- With defaults this is 1600 cycles.

Counters:
- Bit-time counter counts 0..CLKS_PER_BIT-1 and wraps.
- Byte index counts 0..DATA_BYTES+CHECKSUM_EN.
- Checksum adder is 8 bits and wraps; the carry is discarded.

busy: combinational OR of (state != IDLE) and (FIFO non-empty), registered.

Test Plan:
1. Defaults, push data=16'hABCD once -> tx bytes 7B, AB, CD, F3. First bits after start: 1,1,0,1,1,1,1,0. tx falls 2 cycles after the push. frame_done fires once, 1600 cycles after tx falls. busy returns to 0 afterwards.
2. Defaults, 6 consecutive pushes 0x0001..0x0006 from idle -> 0x0001..0x0005 accepted, 0x0006 dropped with a single overflow pulse. Five frames are sent back to back with no idle gap, in order, checksums 7C..80. full asserts after the 5th push.
3. DATA_BYTES=3, CHECKSUM_EN=0, push 24'h123456 -> tx bytes 7B, 12, 34, 56 only. Frame length 1600 cycles at CLKS_PER_BIT=40.
4. CLKS_PER_BIT=4, push 16'h00FF -> every bit period is exactly 4 cycles. Checksum 7A. Frame length 160 cycles.
5. rst asserted for 1 cycle mid-BITS of the data byte, with 2 words queued -> tx=1 from the next cycle; full, busy, frame_done and overflow are 0. Queued words are discarded and tx stays high until a new push.
6. Push on the same edge as a pop while the FIFO is full -> overflow pulses and the FIFO count drops by 1.
